// File: rtl/fu_arbiter_if.sv
// fu_arbiter_if: thread request/response and func_unit bundle.
// master = requester/FU side, slave = arbiter side.
interface fu_arbiter_if #(
   parameter int NUM_THREADS = 4
);
   logic                     launch;
   logic [NUM_THREADS-1:0]   req_valid;
   logic [3*NUM_THREADS-1:0] req_type;
   logic [5*NUM_THREADS-1:0] req_rs1;
   logic [5*NUM_THREADS-1:0] req_rs2;
   logic [5*NUM_THREADS-1:0] req_rd;
   logic [NUM_THREADS-1:0]   req_ready;
   logic [NUM_THREADS-1:0]   resp_valid;
   logic [31:0]              resp_data;
   logic                     resp_err;
   logic [NUM_THREADS-1:0]   thread_done;
   logic                     all_done;
   logic                     busy;
   logic                     fu_issue;
   logic [2:0]               fu_type;
   logic [4:0]               fu_rs1;
   logic [4:0]               fu_rs2;
   logic [4:0]               fu_rd;
   logic [31:0]              fu_result;
   logic                     fu_valid;

   modport master (
      output launch, req_valid, req_type,
      output req_rs1, req_rs2, req_rd,
      output fu_result, fu_valid,
      input  req_ready, resp_valid,
      input  resp_data, resp_err,
      input  thread_done, all_done, busy,
      input  fu_issue, fu_type,
      input  fu_rs1, fu_rs2, fu_rd
   );

   modport slave (
      input  launch, req_valid, req_type,
      input  req_rs1, req_rs2, req_rd,
      input  fu_result, fu_valid,
      output req_ready, resp_valid,
      output resp_data, resp_err,
      output thread_done, all_done, busy,
      output fu_issue, fu_type,
      output fu_rs1, fu_rs2, fu_rd
   );
endinterface

// File: rtl/fu_arbiter.sv
// fu_arbiter: round-robin share of one func_unit lane between threads.
// Ports: clk, rst (sync, active-low), bus (fu_arbiter_if.slave).
module fu_arbiter #(
   parameter int NUM_THREADS    = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   fu_arbiter_if.slave bus
);
   localparam int TW = $clog2(NUM_THREADS);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [2:0] OP_HALT = 3'b111;
   localparam logic [2:0] OP_BAD  = 3'b110;

   typedef enum logic [1:0] {
      IDLE, ISSUE, WAIT, RESP
   } state_e;

   state_e state_q, state_d;
   logic [TW-1:0] rr_q, rr_d;
   logic [TW-1:0] g_q, g_d;
   logic [2:0] op_q, op_d;
   logic [4:0] rs1_q, rs1_d;
   logic [4:0] rs2_q, rs2_d;
   logic [4:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [NUM_THREADS-1:0] done_q, done_d;
   logic [31:0] data_q, data_d;
   logic err_q, err_d;

   logic [NUM_THREADS-1:0] elig;
   logic [TW:0] idx;
   logic [TW-1:0] pick;
   logic found;
   logic fu_act;

   // Rotating scan starting at rr_q; idx is one bit wider
   // so rr_q+k can be folded back modulo NUM_THREADS.
   always_comb begin
      elig  = bus.req_valid & ~done_q;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 0; k < NUM_THREADS; k++) begin
         idx = {1'b0, rr_q} + (TW+1)'(k);
         if (idx >= (TW+1)'(NUM_THREADS))
            idx = idx - (TW+1)'(NUM_THREADS);
         if (!found && elig[idx[TW-1:0]]) begin
            found = 1'b1;
            pick  = idx[TW-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      g_d     = g_q;
      op_d    = op_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      data_d  = data_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               g_d   = pick;
               op_d  = bus.req_type[3*pick +: 3];
               rs1_d = bus.req_rs1[5*pick +: 5];
               rs2_d = bus.req_rs2[5*pick +: 5];
               rd_d  = bus.req_rd[5*pick +: 5];
               if (op_d == OP_HALT) begin
                  data_d  = '0;
                  err_d   = 1'b0;
                  state_d = RESP;
               end else if (op_d == OP_BAD) begin
                  data_d  = 32'hFFFF_FFFF;
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.fu_valid) begin
               data_d  = bus.fu_result;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
               data_d  = 32'hFFFF_FFFF;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (op_q == OP_HALT)
               done_d[g_q] = 1'b1;
            rr_d = (g_q == TW'(NUM_THREADS-1))
                 ? '0 : g_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // launch wins over a halt completing this cycle
      if (bus.launch)
         done_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         g_q     <= '0;
         op_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         done_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         g_q     <= g_d;
         op_q    <= op_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Grant is masked while reset is held so no accept is
   // advertised in a cycle that cannot latch it.
   assign bus.req_ready = (rst && state_q == IDLE && found)
                        ? (NUM_THREADS'(1) << pick) : '0;
   assign bus.resp_valid = (state_q == RESP)
                         ? (NUM_THREADS'(1) << g_q) : '0;
   assign bus.resp_data = (state_q == RESP) ? data_q : '0;
   assign bus.resp_err  = (state_q == RESP) & err_q;

   assign fu_act       = (state_q == ISSUE) || (state_q == WAIT);
   assign bus.fu_issue = (state_q == ISSUE);
   assign bus.fu_type  = fu_act ? op_q : '0;
   assign bus.fu_rs1   = fu_act ? rs1_q : '0;
   assign bus.fu_rs2   = fu_act ? rs2_q : '0;
   assign bus.fu_rd    = fu_act ? rd_q : '0;

   assign bus.busy        = (state_q != IDLE);
   assign bus.thread_done = done_q;
   assign bus.all_done    = &done_q;
endmodule

// File: tb/tb_fu_arbiter.sv
// tb_fu_arbiter: directed checks of fu_arbiter grant,
// issue, timeout, halt/launch and reset behaviour.
module tb_fu_arbiter;
   logic clk;
   logic rst;
   int n_checks;
   int n_fail;

   fu_arbiter_if #(.NUM_THREADS(4)) ifc ();

   fu_arbiter #(
      .NUM_THREADS(4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc();
      cyc();
      #1;
      chk("rst_busy", 32'(ifc.busy), 32'h0);
      chk("rst_ready", 32'(ifc.req_ready), 32'h0);
      chk("rst_resp", 32'(ifc.resp_valid), 32'h0);
      chk("rst_issue", 32'(ifc.fu_issue), 32'h0);
      chk("rst_done", 32'(ifc.thread_done), 32'h0);
      chk("rst_data", ifc.resp_data, 32'h0);
      rst = 1'b1;
   endtask

   // One FU op with fu_valid already held high.
   task automatic run_fu_op(input logic [3:0] m,
                            input logic [31:0] d);
      #1;
      chk("grant", 32'(ifc.req_ready), 32'(m));
      cyc();
      #1;
      chk("op_issue", 32'(ifc.fu_issue), 32'h1);
      cyc();
      cyc();
      #1;
      chk("op_resp", 32'(ifc.resp_valid), 32'(m));
      chk("op_data", ifc.resp_data, d);
      cyc();
   endtask

   initial begin
      logic [3:0] ord [4];
      int waits;
      bit got;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;
      ifc.launch    = 1'b0;
      ifc.req_valid = '0;
      ifc.req_type  = '0;
      ifc.req_rs1   = '0;
      ifc.req_rs2   = '0;
      ifc.req_rd    = '0;
      ifc.fu_result = '0;
      ifc.fu_valid  = 1'b0;
      do_reset();

      // single ADD from thread 0
      ifc.req_valid = 4'b0001;
      ifc.req_rs1[4:0] = 5'd1;
      ifc.req_rs2[4:0] = 5'd2;
      ifc.req_rd[4:0]  = 5'd3;
      #1;
      chk("add_ready", 32'(ifc.req_ready), 32'h1);
      chk("add_idle", 32'(ifc.busy), 32'h0);
      cyc();
      ifc.req_valid = '0;
      #1;
      chk("add_issue", 32'(ifc.fu_issue), 32'h1);
      chk("add_rs1", 32'(ifc.fu_rs1), 32'h1);
      chk("add_rs2", 32'(ifc.fu_rs2), 32'h2);
      chk("add_rd", 32'(ifc.fu_rd), 32'h3);
      chk("add_busy", 32'(ifc.busy), 32'h1);
      cyc();
      ifc.fu_valid  = 1'b1;
      ifc.fu_result = 32'h7;
      #1;
      chk("add_noiss", 32'(ifc.fu_issue), 32'h0);
      chk("add_hold", 32'(ifc.fu_rd), 32'h3);
      cyc();
      ifc.fu_valid = 1'b0;
      #1;
      chk("add_resp", 32'(ifc.resp_valid), 32'h1);
      chk("add_data", ifc.resp_data, 32'h7);
      chk("add_err", 32'(ifc.resp_err), 32'h0);
      chk("add_fu0", 32'(ifc.fu_rs1), 32'h0);
      cyc();
      #1;
      chk("add_end", 32'(ifc.busy), 32'h0);

      // round robin from reset, all requesting
      ifc.req_rs1 = '0;
      ifc.req_rs2 = '0;
      ifc.req_rd  = '0;
      ifc.req_valid = 4'b1111;
      ifc.fu_valid  = 1'b1;
      ifc.fu_result = 32'h55;
      do_reset();
      for (int i = 0; i < 5; i++)
         run_fu_op(4'(1 << (i % 4)), 32'h55);

      // halt from thread 2
      ifc.req_valid = 4'b0100;
      ifc.req_type[8:6] = 3'b111;
      #1;
      chk("halt_ready", 32'(ifc.req_ready), 32'h4);
      cyc();
      ifc.req_valid = '0;
      #1;
      chk("halt_resp", 32'(ifc.resp_valid), 32'h4);
      chk("halt_data", ifc.resp_data, 32'h0);
      chk("halt_err", 32'(ifc.resp_err), 32'h0);
      chk("halt_noiss", 32'(ifc.fu_issue), 32'h0);
      cyc();
      #1;
      chk("halt_done", 32'(ifc.thread_done), 32'h4);
      chk("halt_idle", 32'(ifc.busy), 32'h0);

      // thread 2 skipped afterwards
      ifc.req_valid = 4'b1111;
      run_fu_op(4'b1000, 32'h55);
      run_fu_op(4'b0001, 32'h55);
      run_fu_op(4'b0010, 32'h55);
      run_fu_op(4'b1000, 32'h55);

      ifc.req_valid = '0;
      ifc.launch = 1'b1;
      #1;
      cyc();
      ifc.launch = 1'b0;
      #1;
      chk("launch_clr", 32'(ifc.thread_done), 32'h0);

      // re-grant of thread 2; launch in its RESP cycle
      ifc.req_valid = 4'b0100;
      #1;
      chk("regrant", 32'(ifc.req_ready), 32'h4);
      cyc();
      ifc.req_valid = '0;
      ifc.launch = 1'b1;
      #1;
      chk("re_resp", 32'(ifc.resp_valid), 32'h4);
      cyc();
      ifc.launch = 1'b0;
      #1;
      chk("launch_prio", 32'(ifc.thread_done), 32'h0);

      // every thread halts
      ifc.req_type  = {4{3'b111}};
      ifc.req_valid = 4'b1111;
      ord[0] = 4'b1000;
      ord[1] = 4'b0001;
      ord[2] = 4'b0010;
      ord[3] = 4'b0100;
      for (int j = 0; j < 4; j++) begin
         #1;
         chk("hall_grant", 32'(ifc.req_ready), 32'(ord[j]));
         cyc();
         cyc();
      end
      #1;
      chk("all_done", 32'(ifc.all_done), 32'h1);
      chk("all_mask", 32'(ifc.thread_done), 32'hF);
      chk("all_noreq", 32'(ifc.req_ready), 32'h0);
      ifc.launch = 1'b1;
      ifc.req_valid = '0;
      cyc();
      ifc.launch = 1'b0;
      #1;
      chk("all_clr", 32'(ifc.all_done), 32'h0);

      // timeout with fu_valid low
      ifc.req_type  = '0;
      ifc.fu_valid  = 1'b0;
      ifc.req_valid = 4'b0001;
      #1;
      chk("to_ready", 32'(ifc.req_ready), 32'h1);
      cyc();
      ifc.req_valid = '0;
      #1;
      chk("to_issue", 32'(ifc.fu_issue), 32'h1);
      waits = 0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         cyc();
         #1;
         if (ifc.resp_valid != '0) got = 1'b1;
         else waits++;
      end
      chk("to_waits", 32'(waits), 32'd16);
      chk("to_resp", 32'(ifc.resp_valid), 32'h1);
      chk("to_err", 32'(ifc.resp_err), 32'h1);
      chk("to_data", ifc.resp_data, 32'hFFFF_FFFF);
      cyc();
      #1;
      chk("to_idle", 32'(ifc.busy), 32'h0);

      // unsupported op from thread 1
      ifc.req_type[5:3] = 3'b110;
      ifc.req_valid = 4'b0010;
      #1;
      chk("bad_ready", 32'(ifc.req_ready), 32'h2);
      cyc();
      ifc.req_valid = '0;
      #1;
      chk("bad_noiss", 32'(ifc.fu_issue), 32'h0);
      chk("bad_resp", 32'(ifc.resp_valid), 32'h2);
      chk("bad_err", 32'(ifc.resp_err), 32'h1);
      chk("bad_data", ifc.resp_data, 32'hFFFF_FFFF);
      cyc();
      #1;
      chk("bad_nodone", 32'(ifc.thread_done), 32'h0);
      chk("bad_idle", 32'(ifc.busy), 32'h0);

      // reset during WAIT
      ifc.req_type = '0;
      ifc.req_rd[19:15] = 5'd9;
      ifc.req_valid = 4'b1000;
      #1;
      chk("rw_ready", 32'(ifc.req_ready), 32'h8);
      cyc();
      ifc.req_valid = '0;
      #1;
      cyc();
      rst = 1'b0;
      #1;
      chk("rw_wait", 32'(ifc.busy), 32'h1);
      chk("rw_rd", 32'(ifc.fu_rd), 32'd9);
      cyc();
      ifc.req_valid = 4'b1010;
      #1;
      chk("rw_busy", 32'(ifc.busy), 32'h0);
      chk("rw_resp", 32'(ifc.resp_valid), 32'h0);
      chk("rw_fu", 32'(ifc.fu_rd), 32'h0);
      chk("rw_noreq", 32'(ifc.req_ready), 32'h0);
      rst = 1'b1;
      #1;
      chk("rw_scan0", 32'(ifc.req_ready), 32'h2);
      ifc.req_valid = '0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
